pipe_ctrl: RTL

//  Pipeline sequencer for the IF/ID/EX/MEM stages. Produces per-stage stall/flush, load-hazard bubbles, multi-cycle CP2 waits,
//  and exception entry/return (EPC, PC redirect, interrupt enable). Sits beside the stage registers; id_stage stall/flush come from here.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipe_ctrl_cp2_wait_timer.sv | 35 +++
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, exception codes, control ops.
// Pure declarations; no latency or flow-control behaviour of its own.
package pipe_ctrl_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int ISA_EXP_W   = 3;
    localparam int CTRL_OP_W   = 2;
    localparam int PIPE_ST_W   = 2;

    typedef enum logic [PIPE_ST_W-1:0] {
        PIPE_ST_RUN      = 2'd0,
        PIPE_ST_CP2_WAIT = 2'd1,
        PIPE_ST_EXP      = 2'd2
    } pipe_st_e;

    localparam logic [ISA_EXP_W-1:0]   ISA_EXP_NO_EXP  = 3'd0;
    localparam logic [ISA_EXP_W-1:0]   ISA_EXP_EXT_INT = 3'd1;
    localparam logic [CTRL_OP_W-1:0]   CTRL_OP_EXRT    = 2'd2;

    localparam logic [WORD_ADDR_W-1:0] EXP_VECTOR_DEFAULT  = '0;
    localparam int                     CP2_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/pipe_ctrl_cp2_wait_timer.sv
// CP2 wait counter: 4-bit count with clear > freeze > increment; tc_o when count hits CP2_TIMEOUT.
// Count visible one cycle after enable; freeze holds the count while the memory bus is busy.
module pipe_ctrl_cp2_wait_timer #(
    parameter int CP2_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic freeze_i,
    output logic tc_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!freeze_i && en_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == 4'(CP2_TIMEOUT));

endmodule

// File: rtl/pipe_ctrl.sv
// IF/ID/EX/MEM sequencer: stall/flush decode, CP2 multi-cycle wait, exception entry and return.
// Stall/flush are combinational in the same cycle; EPC/cause/int_en/timeout update on the next edge.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                     CP2_TIMEOUT = CP2_TIMEOUT_DEFAULT,
    parameter logic [WORD_ADDR_W-1:0] EXP_VECTOR  = EXP_VECTOR_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   ld_hazard_i,
    input  logic                   cp2_req_i,
    input  logic                   cp2_done_i,
    input  logic                   bus_busy_i,
    input  logic                   irq_i,
    input  logic                   mem_en_i,
    input  logic [WORD_ADDR_W-1:0] mem_pc_i,
    input  logic [ISA_EXP_W-1:0]   mem_exp_code_i,
    input  logic [CTRL_OP_W-1:0]   mem_ctrl_op_i,
    input  logic [WORD_ADDR_W-1:0] epc_in_i,
    input  logic                   epc_we_i,
    output logic                   if_stall_o,
    output logic                   id_stall_o,
    output logic                   ex_stall_o,
    output logic                   mem_stall_o,
    output logic                   if_flush_o,
    output logic                   id_flush_o,
    output logic                   ex_flush_o,
    output logic                   mem_flush_o,
    output logic [WORD_ADDR_W-1:0] new_pc_o,
    output logic [WORD_ADDR_W-1:0] epc_o,
    output logic [ISA_EXP_W-1:0]   exp_code_o,
    output logic                   int_en_o,
    output logic                   cp2_timeout_o
);

    pipe_st_e               state_q, state_d;
    logic [WORD_ADDR_W-1:0] epc_q;
    logic [ISA_EXP_W-1:0]   exp_code_q;
    logic                   int_en_q;
    logic                   cp2_timeout_q, cp2_timeout_d;
    logic                   exc, eret, exc_take, eret_take;
    logic                   tmr_clr, tmr_en, tmr_freeze, tmr_tc;

    pipe_ctrl_cp2_wait_timer #(.CP2_TIMEOUT(CP2_TIMEOUT)) u_cp2_timer (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .freeze_i (tmr_freeze),
        .tc_o     (tmr_tc)
    );

    assign exc  = mem_en_i & ((mem_exp_code_i != ISA_EXP_NO_EXP) | (irq_i & int_en_q));
    assign eret = mem_en_i & (mem_ctrl_op_i == CTRL_OP_EXRT);

    always_comb begin
        {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o} = 4'b0000;
        {if_flush_o, id_flush_o, ex_flush_o, mem_flush_o} = 4'b0000;
        new_pc_o      = EXP_VECTOR;
        state_d       = state_q;
        cp2_timeout_d = 1'b0;
        exc_take      = 1'b0;
        eret_take     = 1'b0;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
        tmr_freeze    = 1'b0;
        if (state_q == PIPE_ST_EXP) begin
            // IF already fetches from the vector; only the older stages are cleared.
            {id_flush_o, ex_flush_o, mem_flush_o} = 3'b111;
            state_d = PIPE_ST_RUN;
        end else if (exc) begin
            {if_flush_o, id_flush_o, ex_flush_o, mem_flush_o} = 4'b1111;
            exc_take = 1'b1;
            tmr_clr  = 1'b1;
            state_d  = PIPE_ST_EXP;
        end else if (eret) begin
            {if_flush_o, id_flush_o, ex_flush_o, mem_flush_o} = 4'b1111;
            new_pc_o  = epc_q;
            eret_take = 1'b1;
            tmr_clr   = 1'b1;
            state_d   = PIPE_ST_RUN;
        end else if (bus_busy_i) begin
            {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o} = 4'b1111;
            tmr_freeze = 1'b1;
        end else if (state_q == PIPE_ST_CP2_WAIT) begin
            if (cp2_done_i) begin
                tmr_clr = 1'b1;
                state_d = PIPE_ST_RUN;
            end else begin
                {if_stall_o, id_stall_o, ex_stall_o} = 3'b111;
                ex_flush_o = 1'b1;
                if (tmr_tc) begin
                    cp2_timeout_d = 1'b1;
                    tmr_clr       = 1'b1;
                    state_d       = PIPE_ST_RUN;
                end else begin
                    tmr_en = 1'b1;
                end
            end
        end else if (ld_hazard_i) begin
            if_stall_o = 1'b1;
            id_flush_o = 1'b1;
        end else if (cp2_req_i) begin
            tmr_en  = 1'b1;
            state_d = PIPE_ST_CP2_WAIT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= PIPE_ST_RUN;
            epc_q         <= '0;
            exp_code_q    <= ISA_EXP_NO_EXP;
            int_en_q      <= 1'b0;
            cp2_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cp2_timeout_q <= cp2_timeout_d;
            if (exc_take) begin
                epc_q      <= mem_pc_i;
                exp_code_q <= (mem_exp_code_i == ISA_EXP_NO_EXP) ? ISA_EXP_EXT_INT : mem_exp_code_i;
                int_en_q   <= 1'b0;
            end else begin
                if (epc_we_i) begin
                    epc_q <= epc_in_i;
                end
                if (eret_take) begin
                    int_en_q <= 1'b1;
                end
            end
        end
    end

    assign epc_o         = epc_q;
    assign exp_code_o    = exp_code_q;
    assign int_en_o      = int_en_q;
    assign cp2_timeout_o = cp2_timeout_q;

endmodule
